// File: rtl/demux1_2_if.sv
// Stream bundle for demux1_2: one input stream (in_*) and two output streams (out0_*, out1_*).
// slave is the block side; master is the producer/consumer side.
interface demux1_2_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [N-1:0] in_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [N-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [N-1:0] out1_data;

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux1_2.sv
// 1-to-2 valid/ready stream demux with a one-entry registered buffer per output.
// Optional per-port transfer counters cnt0/cnt1 when DEMUX_CNT_EN is defined.
module demux1_2 #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  demux1_2_if.slave         bus
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]       cnt0,
  output logic [31:0]       cnt1
`endif
);

  logic [1:0]        out_rdy;
  logic [1:0]        free;
  logic [1:0]        xfer;
  logic [1:0]        load;
  logic              accept;
  logic [1:0]        valid_q, valid_d;
  logic [1:0][N-1:0] data_q,  data_d;

  assign out_rdy = {bus.out1_ready, bus.out0_ready};
  // A buffer can take a word if empty or being drained this cycle.
  assign free    = ~valid_q | out_rdy;
  assign xfer    = valid_q & out_rdy;

  assign bus.in_ready = free[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = {accept & bus.in_sel, accept & ~bus.in_sel};

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < 2; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end else if (xfer[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.out0_valid = valid_q[0];
  assign bus.out0_data  = data_q[0];
  assign bus.out1_valid = valid_q[1];
  assign bus.out1_data  = data_q[1];

`ifdef DEMUX_CNT_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (xfer[0]) cnt0_d = cnt0_q + 32'd1;
    if (xfer[1]) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/demux1_2.md
# demux1_2

Parametrizable 1-to-2 stream demultiplexer with valid/ready handshake. It is the counterpart of the 2-to-1 data mux: one N-bit input stream is steered by a one-bit select to one of two N-bit output streams. Each output has a one-entry registered buffer, so back-pressure on one output never corrupts data on the other. It sits between a producer, such as a datapath writeback or bus initiator, and two consumers that may stall independently.

## Interface
- N, default 32: data width in bits, N ≥ 1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_sel  input  1  destination: 0 routes to out0, 1 routes to out1; sampled only when in_valid=1.
- in_data  input  N  input word.
- out0_valid / out1_valid  output  1  output buffer holds a word.
- out0_ready / out1_ready  input  1  consumer accepts the word.
- out0_data / out1_data  output  N  buffered word.
- cnt0 / cnt1  output  32  completed output transfers per port; present only with DEMUX_CNT_EN.

## Operation
- Transfer on a port occurs when valid=1 and ready=1 in the same cycle.
- Input acceptance:
  - in_ready = in_sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready).
  - This is combinational from in_sel and the selected port's ready. There is no path from in_valid to in_ready.
- On an accepted input (in_valid & in_ready): the selected buffer loads in_data and its valid becomes 1 at the next edge. The other buffer is unaffected.
- On an output transfer with no new load for that port: valid clears at the next edge. data keeps its last value and is don't-care.
- Same-port drain and fill in the same cycle: new word loads, valid stays 1, full throughput of one word per cycle per port.
- Drain of one port while filling the other in the same cycle: both actions happen independently.
- While outX_valid=1 and outX_ready=0: outX_data and outX_valid hold stable.
- Upstream rule: in_data and in_sel must be held stable while in_valid=1 & in_ready=0. The block does not check this.
- Output valid never depends combinationally on any input.
- Reset:
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0.
  - Any buffered word is discarded, including on reset mid-stream.
  - in_ready during reset follows the formula using the reset state of the buffers.

## Timing
- Latency is 1 cycle: a word accepted at edge k is visible on outX_data with outX_valid=1 after edge k.
- Throughput is 1 word/cycle sustained to either port, provided the consumer holds ready=1.
- Reset takes effect at the first rising edge with rst=1. Outputs are valid from the first edge after rst deasserts.

## Configuration
- DEMUX_CNT_EN defined:
  - cnt0 and cnt1 ports exist.
  - Each counter increments by 1 on every transfer of its port (valid & ready).
  - Counters wrap from 0xFFFFFFFF to 0. Reset clears them.
- DEMUX_CNT_EN undefined:
  - No counter ports or counter logic.
  - All other behaviour is identical.

## Test plan
- Reset, then idle: out0_valid = out1_valid = 0, out data = 0, in_ready = 1 for both in_sel values, cnt0 = cnt1 = 0.
- Send 0xA5A5A5A5 with sel=0, then 0x5A5A5A5A with sel=1, both consumers ready: each appears on its port exactly 1 cycle after acceptance. With DEMUX_CNT_EN, cnt0 = cnt1 = 1.
- Back-pressure: hold out0_ready=0, send 0x11 to port 0, then 0x22 to port 0.
  - in_ready drops for sel=0 and out0_data stays 0x11.
  - Sending 0x33 to port 1 is accepted and delivered meanwhile.
  - Releasing out0_ready delivers 0x11, then 0x22.
- Streaming: 100 back-to-back words alternating sel with both ports ready gives 100 transfers in 101 cycles, with data order preserved per port.
- Reset mid-operation: both buffers full with out ready=0, assert rst for 1 cycle. Both valids read 0 after the edge and the old words are never delivered.
- With DEMUX_CNT_EN: preload by forcing cnt1 = 0xFFFFFFFE, then do 2 transfers on port 1. cnt1 goes to 0xFFFFFFFF, then 0.
